// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NUM_REQ byte-stream requesters. A round-robin grant is
// held for a whole packet (until req_last). One byte is issued per UART frame, and the next
// byte is not taken until tx_done. The UART line configuration is owned here and only ever
// changes between packets, so no frame goes out with mixed settings.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_data/req_last per-requester byte stream (requester i uses req_data[8i+7:8i])
//   req_ready                   byte accepted this cycle (one-hot or zero)
//   cfg_baud_div/cfg_parity/cfg_stop_bits/cfg_update
//                               configuration request; cfg_update captures it into a shadow
//   baud_div/parity_mode/stop_bits
//                               configuration currently applied to the UART
//   tx_data/tx_valid            byte to the UART; tx_valid is a one-cycle pulse
//   tx_ready/tx_done            UART status
//   grant_active/grant_id       current owner of the UART
//   cfg_pending                 shadow configuration waiting to be applied
//   timeout_err                 one-cycle pulse when a stall forces a release
// ---------------------------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned RESET_BAUD_DIV = 16,
    parameter int unsigned TIMEOUT        = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,

    input  logic [15:0]                cfg_baud_div,
    input  logic [1:0]                 cfg_parity,
    input  logic                       cfg_stop_bits,
    input  logic                       cfg_update,

    output logic [15:0]                baud_div,
    output logic [1:0]                 parity_mode,
    output logic                       stop_bits,

    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    input  logic                       tx_done,

    output logic                       grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       cfg_pending,
    output logic                       timeout_err
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCfg,
        StIssue,
        StWaitDone
    } state_e;

    state_e          state_q;
    logic [IdW-1:0]  rr_ptr_q;
    logic [IdW-1:0]  grant_id_q;
    logic            grant_active_q;
    logic            last_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            timeout_err_q;
    logic [CntW-1:0] cnt_q;

    logic [15:0]     shadow_baud_q;
    logic [1:0]      shadow_parity_q;
    logic            shadow_stop_q;
    logic            cfg_pending_q;
    logic [15:0]     baud_div_q;
    logic [1:0]      parity_mode_q;
    logic            stop_bits_q;

    // ------------------------------------------------------------------
    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    // ------------------------------------------------------------------
    logic [IdW-1:0] pick;
    logic           pick_vld;

    always_comb begin : p_rr_pick
        int unsigned    idx;
        logic [IdW-1:0] cand;
        idx      = 0;
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = idx[IdW-1:0];
            if (!pick_vld && req_valid[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // Pointer value after releasing the current owner.
    logic [IdW-1:0] rr_next;
    assign rr_next = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    // ------------------------------------------------------------------
    // Accept handshake with the granted requester.
    // ------------------------------------------------------------------
    logic       accept;
    logic [7:0] grant_byte;

    assign accept     = (state_q == StIssue) && tx_ready && req_valid[grant_id_q];
    assign grant_byte = req_data[{grant_id_q, 3'b000} +: 8];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: grant, issue, wait for tx_done, release; configuration
    // is applied only from IDLE through the one-cycle CFG state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            rr_ptr_q        <= '0;
            grant_id_q      <= '0;
            grant_active_q  <= 1'b0;
            last_q          <= 1'b0;
            tx_data_q       <= '0;
            tx_valid_q      <= 1'b0;
            timeout_err_q   <= 1'b0;
            cnt_q           <= '0;
            shadow_baud_q   <= 16'(RESET_BAUD_DIV);
            shadow_parity_q <= '0;
            shadow_stop_q   <= 1'b0;
            cfg_pending_q   <= 1'b0;
            baud_div_q      <= 16'(RESET_BAUD_DIV);
            parity_mode_q   <= '0;
            stop_bits_q     <= 1'b0;
        end else begin
            tx_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;

            // Capture is allowed in any state; the last update wins.
            if (cfg_update) begin
                shadow_baud_q   <= cfg_baud_div;
                shadow_parity_q <= cfg_parity;
                shadow_stop_q   <= cfg_stop_bits;
                cfg_pending_q   <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (cfg_pending_q) begin
                        state_q <= StCfg;
                    end else if (pick_vld) begin
                        grant_id_q     <= pick;
                        grant_active_q <= 1'b1;
                        cnt_q          <= '0;
                        state_q        <= StIssue;
                    end
                end

                StCfg: begin
                    baud_div_q    <= shadow_baud_q;
                    parity_mode_q <= shadow_parity_q;
                    stop_bits_q   <= shadow_stop_q;
                    // A same-cycle update lands in the shadow and must stay pending.
                    if (!cfg_update) begin
                        cfg_pending_q <= 1'b0;
                    end
                    state_q <= StIdle;
                end

                StIssue: begin
                    if (accept) begin
                        tx_data_q  <= grant_byte;
                        last_q     <= req_last[grant_id_q];
                        tx_valid_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= StWaitDone;
                    end else if (!req_valid[grant_id_q]) begin
                        // Only a silent owner counts toward the stall limit.
                        if (cnt_q == CntMax) begin
                            timeout_err_q  <= 1'b1;
                            grant_active_q <= 1'b0;
                            rr_ptr_q       <= rr_next;
                            cnt_q          <= '0;
                            state_q        <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                StWaitDone: begin
                    // tx_done takes priority over a simultaneous expiry.
                    if (tx_done) begin
                        cnt_q <= '0;
                        if (last_q) begin
                            grant_active_q <= 1'b0;
                            rr_ptr_q       <= rr_next;
                            state_q        <= StIdle;
                        end else begin
                            state_q <= StIssue;
                        end
                    end else if (cnt_q == CntMax) begin
                        timeout_err_q  <= 1'b1;
                        grant_active_q <= 1'b0;
                        rr_ptr_q       <= rr_next;
                        cnt_q          <= '0;
                        state_q        <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign baud_div     = baud_div_q;
    assign parity_mode  = parity_mode_q;
    assign stop_bits    = stop_bits_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign grant_active = grant_active_q;
    assign grant_id     = grant_id_q;
    assign cfg_pending  = cfg_pending_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Requesters are modelled as per-requester byte queues;
// a UART stub answers each tx_valid with tx_done ten cycles later. Every byte loaded is also
// pushed to a scoreboard together with the owner and line configuration it must be sent with;
// each tx_valid pops and compares one entry.
// ---------------------------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int unsigned NumReq  = 4;
    localparam int unsigned DoneDly = 10;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NumReq-1:0]   req_valid = '0;
    logic [NumReq*8-1:0] req_data = '0;
    logic [NumReq-1:0]   req_last = '0;
    logic [NumReq-1:0]   req_ready;
    logic [15:0]         cfg_baud_div = '0;
    logic [1:0]          cfg_parity = '0;
    logic                cfg_stop_bits = 1'b0;
    logic                cfg_update = 1'b0;
    logic [15:0]         baud_div;
    logic [1:0]          parity_mode;
    logic                stop_bits;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready = 1'b1;
    logic                tx_done = 1'b0;
    logic                grant_active;
    logic [1:0]          grant_id;
    logic                cfg_pending;
    logic                timeout_err;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [8:0]  q2[$];
    logic [8:0]  q3[$];
    logic [31:0] sb[$];

    logic [15:0] exp_baud = 16'd16;
    logic [1:0]  exp_par  = 2'd0;
    logic        exp_stop = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ        (NumReq),
        .RESET_BAUD_DIV (16),
        .TIMEOUT        (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .cfg_baud_div  (cfg_baud_div),
        .cfg_parity    (cfg_parity),
        .cfg_stop_bits (cfg_stop_bits),
        .cfg_update    (cfg_update),
        .baud_div      (baud_div),
        .parity_mode   (parity_mode),
        .stop_bits     (stop_bits),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_done       (tx_done),
        .grant_active  (grant_active),
        .grant_id      (grant_id),
        .cfg_pending   (cfg_pending),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [2:0] gid, input logic stop,
                                         input logic [1:0] par, input logic [15:0] baud,
                                         input logic [7:0] d);
        return {2'b00, gid, stop, par, baud, d};
    endfunction

    // Load a byte into requester id's queue and record how it must appear at the UART.
    task automatic load(input int id, input logic [7:0] d, input logic last);
        sb.push_back(pack(3'(id), exp_stop, exp_par, exp_baud, d));
        case (id)
            0:       q0.push_back({last, d});
            1:       q1.push_back({last, d});
            2:       q2.push_back({last, d});
            default: q3.push_back({last, d});
        endcase
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'h0);
        check({tag, "_grant_active"}, 32'(grant_active), 32'h0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'h0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
        check({tag, "_cfg_pending"}, 32'(cfg_pending), 32'h0);
        check({tag, "_baud_div"}, 32'(baud_div), 32'd16);
        check({tag, "_parity"}, 32'(parity_mode), 32'h0);
        check({tag, "_stop"}, 32'(stop_bits), 32'h0);
    endtask

    // Wait until all loaded traffic has gone out and the arbiter is idle again.
    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && grant_active === 1'b0 && tx_ready === 1'b1 &&
                req_valid === '0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_drained"}, 32'(ok), 32'h1);
    endtask

    task automatic wait_tx_done(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_tx_done_seen"}, 32'(ok), 32'h1);
    endtask

    // Requester model: a byte seen with req_ready before the edge is consumed after it.
    always begin : req_driver
        logic [NumReq-1:0] acc;
        logic [8:0]        fr;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        if (acc[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc[1] && q1.size() > 0) void'(q1.pop_front());
        if (acc[2] && q2.size() > 0) void'(q2.pop_front());
        if (acc[3] && q3.size() > 0) void'(q3.pop_front());
        fr = (q0.size() > 0) ? q0[0] : 9'h0;
        req_valid[0] = (q0.size() > 0); req_last[0] = fr[8]; req_data[7:0] = fr[7:0];
        fr = (q1.size() > 0) ? q1[0] : 9'h0;
        req_valid[1] = (q1.size() > 0); req_last[1] = fr[8]; req_data[15:8] = fr[7:0];
        fr = (q2.size() > 0) ? q2[0] : 9'h0;
        req_valid[2] = (q2.size() > 0); req_last[2] = fr[8]; req_data[23:16] = fr[7:0];
        fr = (q3.size() > 0) ? q3[0] : 9'h0;
        req_valid[3] = (q3.size() > 0); req_last[3] = fr[8]; req_data[31:24] = fr[7:0];
    end

    // UART stub and scoreboard consumer.
    always begin : uart_stub
        int busy;
        busy = 0;
        forever begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'h1);
                if (sb.size() != 0) begin
                    check("tx_frame", pack({1'b0, grant_id}, stop_bits, parity_mode, baud_div,
                                           tx_data), sb.pop_front());
                end
                busy = DoneDly;
            end
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (!rst_n) begin
                busy = 0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) tx_done = 1'b1;
            end
            tx_ready = (busy == 0) && !tx_done;
        end
    end

    initial begin
        bit ok;

        // Power-on reset.
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester, best-case latency.
        load(0, 8'hA5, 1'b1);
        @(negedge clk);
        check("t1_c0_grant", 32'(grant_active), 32'h0);
        check("t1_c0_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        check("t1_c1_ready", 32'(req_ready), 32'h1);
        check("t1_c1_grant", 32'(grant_active), 32'h1);
        check("t1_c1_gid", 32'(grant_id), 32'h0);
        @(negedge clk);
        check("t1_c2_valid", 32'(tx_valid), 32'h1);
        check("t1_c2_data", 32'(tx_data), 32'hA5);
        @(negedge clk);
        check("t1_c3_valid", 32'(tx_valid), 32'h0);
        wait_tx_done("t1");
        check("t1_grant_at_done", 32'(grant_active), 32'h1);
        @(negedge clk);
        check("t1_grant_after_done", 32'(grant_active), 32'h0);
        drain("t1");

        // Two 3-byte packets: no interleaving.
        load(0, 8'h10, 1'b0);
        load(0, 8'h11, 1'b0);
        load(0, 8'h12, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (grant_active === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("t2_first_grant", 32'(ok), 32'h1);
        load(2, 8'h20, 1'b0);
        load(2, 8'h21, 1'b0);
        load(2, 8'h22, 1'b1);
        drain("t2");
        // rr_ptr is now 3: requester 0 wins over 2, then 2 is served.
        load(0, 8'h13, 1'b1);
        load(2, 8'h23, 1'b1);
        drain("t2_round3");
        load(3, 8'h33, 1'b1);
        drain("t2_req3");

        // All four requesting continuously: 0,1,2,3,0,1,2,3.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                load(i, 8'(8'h40 + 16 * r + i), 1'b1);
            end
        end
        drain("t3");

        // Configuration update mid-packet.
        load(1, 8'h61, 1'b0);
        load(1, 8'h62, 1'b0);
        load(1, 8'h63, 1'b1);
        exp_baud = 16'd32;
        exp_par  = 2'd1;
        exp_stop = 1'b1;
        load(2, 8'h70, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_first_byte", 32'(ok), 32'h1);
        @(posedge clk);
        #1;
        cfg_baud_div  = 16'd32;
        cfg_parity    = 2'd1;
        cfg_stop_bits = 1'b1;
        cfg_update    = 1'b1;
        @(posedge clk);
        #1;
        cfg_update = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (grant_active !== 1'b1) begin
                ok = 1'b1;
                break;
            end
            check("t4_hold_baud", 32'(baud_div), 32'd16);
            check("t4_hold_par", 32'(parity_mode), 32'd0);
            check("t4_hold_stop", 32'(stop_bits), 32'd0);
            check("t4_hold_pend", 32'(cfg_pending), 32'h1);
        end
        check("t4_release", 32'(ok), 32'h1);
        check("t4_idle_pend", 32'(cfg_pending), 32'h1);
        check("t4_idle_baud", 32'(baud_div), 32'd16);
        @(negedge clk);
        check("t4_cfg_grant", 32'(grant_active), 32'h0);
        check("t4_cfg_pend", 32'(cfg_pending), 32'h1);
        check("t4_cfg_baud", 32'(baud_div), 32'd16);
        @(negedge clk);
        check("t4_new_baud", 32'(baud_div), 32'd32);
        check("t4_new_par", 32'(parity_mode), 32'd1);
        check("t4_new_stop", 32'(stop_bits), 32'd1);
        check("t4_new_pend", 32'(cfg_pending), 32'h0);
        check("t4_new_grant", 32'(grant_active), 32'h0);
        @(negedge clk);
        check("t4_next_grant", 32'(grant_active), 32'h1);
        check("t4_next_gid", 32'(grant_id), 32'd2);
        drain("t4");

        // Locked requester 3 goes silent after a non-last byte.
        load(3, 8'h81, 1'b0);
        load(0, 8'h90, 1'b1);
        wait_tx_done("t5");
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k < 65) begin
                check("t5_no_err", 32'(timeout_err), 32'h0);
                check("t5_held", 32'(grant_active), 32'h1);
            end else begin
                check("t5_err_pulse", 32'(timeout_err), 32'h1);
                check("t5_released", 32'(grant_active), 32'h0);
            end
        end
        @(negedge clk);
        check("t5_err_single", 32'(timeout_err), 32'h0);
        drain("t5");

        // Reset during WAIT_DONE, with a configuration pending.
        load(1, 8'h55, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_sent", 32'(ok), 32'h1);
        @(posedge clk);
        #1;
        cfg_baud_div  = 16'd99;
        cfg_parity    = 2'd2;
        cfg_stop_bits = 1'b1;
        cfg_update    = 1'b1;
        @(posedge clk);
        #1;
        cfg_update = 1'b0;
        #2;
        check("t6_pre_pend", 32'(cfg_pending), 32'h1);
        check("t6_pre_grant", 32'(grant_active), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset("t6_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_baud = 16'd16;
        exp_par  = 2'd0;
        exp_stop = 1'b0;
        load(1, 8'h3C, 1'b1);
        drain("t6");

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_top` transmitter among `NUM_REQ` byte-stream requesters. It grants the UART to one requester at a time and holds that grant across a multi-byte packet until `req_last`. It issues one byte per UART frame and waits for `tx_done` before issuing the next byte. It owns the UART line configuration (`baud_div`, `parity_mode`, `stop_bits`) and changes it only between packets, so no frame is ever sent with mixed settings.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `RESET_BAUD_DIV`, 16: `baud_div` value after reset.
- `TIMEOUT`, 4096: cycle limit for a stalled locked requester or a missing `tx_done`.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in NUM_REQ*8: per-requester byte; requester i uses bits [8i+7:8i].
- `req_last` in NUM_REQ: marks the byte as the final byte of its packet.
- `req_ready` out NUM_REQ: byte accepted; one-hot or zero.
- `cfg_baud_div` in 16: requested clocks per bit.
- `cfg_parity` in 2: 0 = none, 1 = even, 2 = odd.
- `cfg_stop_bits` in 1: 0 = one stop bit, 1 = two stop bits.
- `cfg_update` in 1: one-cycle pulse; captures the three `cfg_*` inputs.
- `baud_div` out 16, `parity_mode` out 2, `stop_bits` out 1: registered UART configuration.
- `tx_data` out 8, `tx_valid` out 1: to the UART; `tx_valid` is a one-cycle pulse.
- `tx_ready` in 1, `tx_done` in 1: from the UART.
- `grant_active` out 1, `grant_id` out clog2(NUM_REQ): current owner of the UART.
- `cfg_pending` out 1: a captured configuration is waiting to be applied.
- `timeout_err` out 1: one-cycle pulse when a timeout forces a release.

## Operation
- Reset values:
  - `req_ready` = 0, `tx_valid` = 0, `tx_data` = 0.
  - `grant_active` = 0, `grant_id` = 0, `timeout_err` = 0, `cfg_pending` = 0.
  - `baud_div` = RESET_BAUD_DIV, `parity_mode` = 0, `stop_bits` = 0.
  - Round-robin pointer `rr_ptr` = 0; state = IDLE.
- States:
  - IDLE:
    - If `cfg_pending`, go to CFG.
    - Otherwise, if any `req_valid`, grant the first valid index searching upward from `rr_ptr` with wrap. Set `grant_id` and `grant_active`, then go to ISSUE.
  - CFG (one cycle):
    - Copy the shadow configuration to the outputs and clear `cfg_pending`, then return to IDLE.
    - If `cfg_update` arrives in this same cycle, the new values are captured into the shadow and `cfg_pending` stays 1.
  - ISSUE: while `tx_ready` and `req_valid[g]` are both 1, drive `req_ready[g]` = 1 combinationally. On that accept, register the byte and its `req_last` flag, then go to WAIT_DONE.
  - WAIT_DONE:
    - Assert `tx_valid` for the first cycle only, with `tx_data` set to the registered byte.
    - On `tx_done`:
      - If the registered last flag is 1, release: clear `grant_active`, set `rr_ptr` = (g+1) mod NUM_REQ, go to IDLE.
      - Otherwise go to ISSUE with the grant held.
- `cfg_update` handling:
  - It is accepted in any state and writes the shadow register; the last update wins.
  - It sets `cfg_pending`. The outputs change only in CFG, i.e. never while a grant is held.
- Timeout:
  - One counter runs in ISSUE (while `req_valid[g]` = 0) and in WAIT_DONE. It clears on every state entry.
  - When it reaches TIMEOUT-1, pulse `timeout_err`, release exactly as on a normal release (`rr_ptr` advances), and go to IDLE.
- Non-granted requesters see `req_ready` = 0 at all times.

## Timing
- A grant is registered; `req_ready` and the UART outputs follow from state.
- Best-case latency, UART idle and `req_valid` high at cycle 0:
  - Cycle 0: IDLE, grant captured.
  - Cycle 1: ISSUE, `req_ready` = 1.
  - Cycle 2: `tx_valid` = 1.
- Per byte: `tx_done` cycle, then ISSUE (next accept is one cycle later at the earliest), then `tx_valid` the cycle after that.
- A pending configuration adds exactly one cycle (CFG) before the next grant.
- If `tx_done` and the timeout expiry occur in the same cycle, `tx_done` wins: no `timeout_err`, normal path.
- Reset asserted mid-frame forces every output to its reset value immediately. The shadow configuration and the grant are lost. The UART shares the same `rst_n`.

## Test plan
- Single requester, byte 0xA5 with last=1, UART stub `tx_done` 10 cycles after `tx_valid`:
  - `req_ready` at cycle 1, `tx_valid`/0xA5 at cycle 2, `grant_active` falls one cycle after `tx_done`, `rr_ptr` = 1.
- Requesters 0 and 2 both hold 3-byte packets (0x10..0x12 and 0x20..0x22):
  - UART sees 10, 11, 12, 20, 21, 22 with no interleaving.
  - A third round starting at `rr_ptr` = 3 picks requester 0.
- All four requesters each send one last=1 byte, every cycle repeated:
  - Grant order 0, 1, 2, 3, 0.
  - No requester is granted twice before all others have been granted.
- `cfg_update` (baud 32, even parity, two stop bits) pulsed mid-packet:
  - Outputs stay 16/0/0 until the packet's final `tx_done`.
  - One CFG cycle, then outputs are 32/1/1 before the next grant; `cfg_pending` is 1 throughout the wait.
- Locked requester drops `req_valid` after byte 1 of a non-last packet, TIMEOUT = 64:
  - `timeout_err` pulses once, 64 cycles into ISSUE; the grant is released; the next requester is served.
- `rst_n` low during WAIT_DONE:
  - All outputs take their reset values asynchronously.
  - After release, a 0x3C last=1 byte from requester 1 is sent normally with `baud_div` = 16.
